// File: rtl/formal_output_checker_if.sv
// Vector/result bundle between a stimulus source and the formal output checker.
// The master drives the compared vectors; the slave (the checker) returns the verdict.
interface formal_output_checker_if #(
  parameter int WIDTH = 18,
  parameter int CNT_W = 16
);
  logic             start;
  logic             vec_valid;
  logic [WIDTH-1:0] gfpga_out;
  logic [WIDTH-1:0] bench_out;
  logic [WIDTH-1:0] bench_x_mask;
  logic [WIDTH-1:0] mismatch_flag;
  logic [CNT_W-1:0] nb_error;
  logic [CNT_W-1:0] first_err_idx;
  logic [WIDTH-1:0] first_err_bits;
  logic             busy;
  logic             done;
  logic             pass;

  modport master (
    output start, vec_valid, gfpga_out, bench_out, bench_x_mask,
    input  mismatch_flag, nb_error, first_err_idx, first_err_bits, busy, done, pass
  );

  modport slave (
    input  start, vec_valid, gfpga_out, bench_out, bench_x_mask,
    output mismatch_flag, nb_error, first_err_idx, first_err_bits, busy, done, pass
  );
endinterface

// File: rtl/formal_output_checker.sv
// Compares fabric outputs against a reference benchmark once per accepted vector after a
// warm-up skip, counting per-bit mismatch rising edges and capturing the first failure.
module formal_output_checker #(
  parameter int WIDTH       = 18,
  parameter int SKIP_CYCLES = 1,
  parameter int NUM_VECTORS = 10,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  formal_output_checker_if.slave bus
);

  localparam int POP_W = $clog2(WIDTH + 1);
  localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
  localparam logic [7:0]       SKIP_LAST = (SKIP_CYCLES > 0) ? 8'(SKIP_CYCLES - 1) : 8'd0;
  localparam logic [CNT_W-1:0] VEC_LAST  = CNT_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SKIP  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam state_t START_STATE = (SKIP_CYCLES > 0) ? S_SKIP : S_CHECK;

  function automatic logic [POP_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [POP_W-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + POP_W'(v[i]);
    end
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [POP_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    return (s > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(s);
  endfunction

  state_t           state_q;
  logic [7:0]       skip_cnt_q;
  logic [CNT_W-1:0] vec_cnt_q;
  logic [WIDTH-1:0] mismatch_flag_q;
  logic [CNT_W-1:0] nb_error_q;
  logic [CNT_W-1:0] first_err_idx_q;
  logic [WIDTH-1:0] first_err_bits_q;
  logic             err_seen_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] mm_d;
  logic [WIDTH-1:0] rise_d;
  logic [CNT_W-1:0] nb_error_d;

  // Only bits that were clean (or masked) on the previous compared vector may count again.
  always_comb begin
    mm_d       = (bus.gfpga_out ^ bus.bench_out) & ~bus.bench_x_mask;
    rise_d     = mm_d & ~mismatch_flag_q;
    nb_error_d = sat_add(nb_error_q, popcount(rise_d));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      skip_cnt_q       <= '0;
      vec_cnt_q        <= '0;
      mismatch_flag_q  <= '0;
      nb_error_q       <= '0;
      first_err_idx_q  <= '0;
      first_err_bits_q <= '0;
      err_seen_q       <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
    end else if (bus.start) begin
      state_q          <= START_STATE;
      skip_cnt_q       <= '0;
      vec_cnt_q        <= '0;
      mismatch_flag_q  <= '0;
      nb_error_q       <= '0;
      first_err_idx_q  <= '0;
      first_err_bits_q <= '0;
      err_seen_q       <= 1'b0;
      busy_q           <= 1'b1;
      done_q           <= 1'b0;
    end else begin
      case (state_q)
        S_SKIP: begin
          if (bus.vec_valid) begin
            skip_cnt_q <= skip_cnt_q + 8'd1;
            if (skip_cnt_q == SKIP_LAST) begin
              state_q <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (bus.vec_valid) begin
            mismatch_flag_q <= mm_d;
            nb_error_q      <= nb_error_d;
            if ((mm_d != '0) && !err_seen_q) begin
              err_seen_q       <= 1'b1;
              first_err_idx_q  <= vec_cnt_q;
              first_err_bits_q <= mm_d;
            end
            vec_cnt_q <= vec_cnt_q + 1'b1;
            if (vec_cnt_q == VEC_LAST) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        S_IDLE, S_DONE: begin
          state_q <= state_q;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mismatch_flag  = mismatch_flag_q;
  assign bus.nb_error       = nb_error_q;
  assign bus.first_err_idx  = first_err_idx_q;
  assign bus.first_err_bits = first_err_bits_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = done_q & (nb_error_q == '0);

endmodule

// File: tb/tb_formal_output_checker.sv
// Bench for formal_output_checker: two instances (16-bit and 4-bit counters) share stimulus;
// expected run results are queued at run start and popped when each instance raises done.
module tb_formal_output_checker;

  logic clk;
  logic reset;

  formal_output_checker_if #(.WIDTH(18), .CNT_W(16)) ia ();
  formal_output_checker_if #(.WIDTH(18), .CNT_W(4))  ib ();

  assign ib.start        = ia.start;
  assign ib.vec_valid    = ia.vec_valid;
  assign ib.gfpga_out    = ia.gfpga_out;
  assign ib.bench_out    = ia.bench_out;
  assign ib.bench_x_mask = ia.bench_x_mask;

  formal_output_checker #(.WIDTH(18), .SKIP_CYCLES(1), .NUM_VECTORS(10), .CNT_W(16)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ia)
  );

  formal_output_checker #(.WIDTH(18), .SKIP_CYCLES(1), .NUM_VECTORS(10), .CNT_W(4)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] nb;
    logic [31:0] idx;
    logic [17:0] bits;
    logic        pass;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int total = 0;
  int bad   = 0;

  logic [17:0] errv [0:10];
  logic [17:0] mskv [0:10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] pat(input int i);
    logic [31:0] t;
    t = ((i + 1) * 32'h0002_B3C5) ^ 32'h0001_5A5A;
    return t[17:0];
  endfunction

  // Hand-computed run result; the 4-bit counter instance sees the same value clipped at 15.
  task automatic push_exp(input int nb, input int idx, input logic [17:0] bits);
    exp_t e;
    e.nb = nb; e.idx = idx; e.bits = bits; e.pass = (nb == 0);
    qa.push_back(e);
    e.nb = (nb > 15) ? 15 : nb;
    qb.push_back(e);
  endtask

  task automatic clear_vecs();
    for (int i = 0; i <= 10; i++) begin
      errv[i] = '0;
      mskv[i] = '0;
    end
  endtask

  task automatic do_start(input logic vv);
    ia.start        = 1'b1;
    ia.vec_valid    = vv;
    ia.bench_out    = 18'h12345;
    ia.gfpga_out    = ~18'h12345;
    ia.bench_x_mask = '0;
    @(posedge clk); #1;
    ia.start     = 1'b0;
    ia.vec_valid = 1'b0;
  endtask

  task automatic send(input int i, input int gap);
    ia.vec_valid    = 1'b1;
    ia.bench_out    = pat(i);
    ia.gfpga_out    = pat(i) ^ errv[i];
    ia.bench_x_mask = mskv[i];
    @(posedge clk); #1;
    ia.vec_valid    = 1'b0;
    ia.gfpga_out    = ~pat(i);
    ia.bench_x_mask = '0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_full(input int gap);
    for (int i = 0; i <= 10; i++) begin
      send(i, gap);
      if (i == 9) begin
        chk("done_before_last", {31'd0, ia.done}, 32'd0);
        chk("busy_before_last", {31'd0, ia.busy}, 32'd1);
      end
    end
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: pops one expected result per done rising edge on each instance.
  initial begin
    logic pa, pb;
    exp_t e;
    pa = 1'b0;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      if (ia.done && !pa) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_done", 32'd1, 32'd0);
        end else begin
          e = qa.pop_front();
          chk("a_nb_error", 32'(ia.nb_error), e.nb);
          chk("a_first_err_idx", 32'(ia.first_err_idx), e.idx);
          chk("a_first_err_bits", 32'(ia.first_err_bits), 32'(e.bits));
          chk("a_pass", {31'd0, ia.pass}, {31'd0, e.pass});
          chk("a_busy_at_done", {31'd0, ia.busy}, 32'd0);
        end
      end
      if (ib.done && !pb) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_done", 32'd1, 32'd0);
        end else begin
          e = qb.pop_front();
          chk("b_nb_error", 32'(ib.nb_error), e.nb);
          chk("b_first_err_idx", 32'(ib.first_err_idx), e.idx);
          chk("b_first_err_bits", 32'(ib.first_err_bits), 32'(e.bits));
          chk("b_pass", {31'd0, ib.pass}, {31'd0, e.pass});
        end
      end
      pa = ia.done;
      pb = ib.done;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    ia.start        = 1'b0;
    ia.vec_valid    = 1'b0;
    ia.gfpga_out    = '0;
    ia.bench_out    = '0;
    ia.bench_x_mask = '0;
    clear_vecs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mismatch_flag", 32'(ia.mismatch_flag), 32'd0);
    chk("rst_nb_error", 32'(ia.nb_error), 32'd0);
    chk("rst_first_err_idx", 32'(ia.first_err_idx), 32'd0);
    chk("rst_first_err_bits", 32'(ia.first_err_bits), 32'd0);
    chk("rst_busy", {31'd0, ia.busy}, 32'd0);
    chk("rst_done", {31'd0, ia.done}, 32'd0);
    chk("rst_pass", {31'd0, ia.pass}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: all clean
    clear_vecs();
    push_exp(0, 0, 18'h00000);
    do_start(1'b0);
    chk("busy_after_start", {31'd0, ia.busy}, 32'd1);
    run_full(0);
    chk("done_held", {31'd0, ia.done}, 32'd1);

    // 2: bit 3 differs in skipped vector and in check vector 0
    clear_vecs();
    errv[0] = 18'h00008;
    errv[1] = 18'h00008;
    push_exp(1, 0, 18'h00008);
    do_start(1'b0);
    run_full(0);

    // 3: bit 5 on check vectors 2,3,4 and 6; gaps and a valid start-cycle vector are ignored
    clear_vecs();
    errv[3] = 18'h00020;
    errv[4] = 18'h00020;
    errv[5] = 18'h00020;
    errv[7] = 18'h00020;
    push_exp(2, 2, 18'h00020);
    do_start(1'b1);
    run_full(1);

    // 4: everything masked, everything differs
    for (int i = 0; i <= 10; i++) begin
      errv[i] = 18'h3FFFF;
      mskv[i] = 18'h3FFFF;
    end
    push_exp(0, 0, 18'h00000);
    do_start(1'b0);
    run_full(0);
    chk("masked_flag", 32'(ia.mismatch_flag), 32'd0);

    // 5: all bits on check vectors 1 and 3, clean between
    clear_vecs();
    errv[2] = 18'h3FFFF;
    errv[4] = 18'h3FFFF;
    push_exp(36, 1, 18'h3FFFF);
    do_start(1'b0);
    for (int i = 0; i <= 10; i++) begin
      send(i, 0);
      if (i == 2) begin
        chk("all_bits_nb_a", 32'(ia.nb_error), 32'd18);
        chk("all_bits_nb_b", 32'(ib.nb_error), 32'd15);
        chk("all_bits_flag", 32'(ia.mismatch_flag), 32'h3FFFF);
      end
      if (i == 3) begin
        chk("rearm_flag", 32'(ia.mismatch_flag), 32'd0);
      end
    end
    repeat (2) begin
      @(posedge clk); #1;
    end

    // 6: restart after check vector 4 of a failing run
    clear_vecs();
    errv[3] = 18'h00001;
    errv[5] = 18'h00002;
    do_start(1'b0);
    for (int i = 0; i <= 5; i++) send(i, 0);
    chk("midrun_nb", 32'(ia.nb_error), 32'd2);
    do_start(1'b0);
    chk("restart_nb", 32'(ia.nb_error), 32'd0);
    chk("restart_done", {31'd0, ia.done}, 32'd0);
    chk("restart_busy", {31'd0, ia.busy}, 32'd1);
    chk("restart_bits", 32'(ia.first_err_bits), 32'd0);
    chk("restart_flag", 32'(ia.mismatch_flag), 32'd0);
    clear_vecs();
    errv[8] = 18'h20000;
    push_exp(1, 7, 18'h20000);
    run_full(0);

    // reset mid-run discards everything
    clear_vecs();
    errv[2] = 18'h3FFFF;
    do_start(1'b0);
    for (int i = 0; i <= 4; i++) send(i, 0);
    chk("pre_reset_nb", 32'(ia.nb_error), 32'd18);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_nb", 32'(ia.nb_error), 32'd0);
    chk("midrst_flag", 32'(ia.mismatch_flag), 32'd0);
    chk("midrst_bits", 32'(ia.first_err_bits), 32'd0);
    chk("midrst_busy", {31'd0, ia.busy}, 32'd0);
    chk("midrst_done", {31'd0, ia.done}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // recovery run: error only in the skipped vector
    clear_vecs();
    errv[0] = 18'h3FFFF;
    push_exp(0, 0, 18'h00000);
    do_start(1'b0);
    run_full(0);

    chk("queue_a_drained", 32'(qa.size()), 32'd0);
    chk("queue_b_drained", 32'(qb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
